// File: rtl/neuron_seq_if.sv
// neuron_seq_if: bundles the activation input, weight ROM port, ReLU link and
// result output of one neuron sequencer.
// master = the sequencer side, slave = the surrounding layer / testbench side.
interface neuron_seq_if #(
    parameter int dataWidth = 16,
    parameter int addrWidth = 10
);
    logic [dataWidth-1:0]   in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [addrWidth-1:0]   w_addr;
    logic                   w_rd_en;
    logic [dataWidth-1:0]   w_data;
    logic [2*dataWidth-1:0] bias;
    logic [2*dataWidth-1:0] act_x;
    logic [dataWidth-1:0]   act_y;
    logic [dataWidth-1:0]   out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        input  in_data, in_valid, w_data, bias, act_y, out_ready,
        output in_ready, w_addr, w_rd_en, act_x, out_data, out_valid, busy
    );

    modport slave (
        output in_data, in_valid, w_data, bias, act_y, out_ready,
        input  in_ready, w_addr, w_rd_en, act_x, out_data, out_valid, busy
    );
endinterface

// File: rtl/neuron_seq.sv
// neuron_seq: per-neuron MAC sequencer feeding an external registered ReLU.
// Optional feature macro: NEURON_BIAS_EN -- when defined, a BIAS state adds the
// bias input to the accumulator (saturating) before activation; when undefined
// the bias port is ignored and DRAIN goes straight to ACT.
module neuron_seq #(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4,
    parameter int numWeight      = 784,
    parameter int addrWidth      = 10
) (
    input  logic             clk,
    input  logic             rst,
    neuron_seq_if.master     bus
);
    localparam int AW = 2 * dataWidth;
    localparam logic [addrWidth-1:0] LAST_IDX = addrWidth'(numWeight - 1);
    // weightIntWidth only matters to the paired ReLU; kept for a uniform parameter list
    localparam int unused_weight_int_width = weightIntWidth;

`ifdef NEURON_BIAS_EN
    typedef enum logic [2:0] {ACC, DRAIN, BIAS, ACT, CAPT, OUT} state_t;
`else
    typedef enum logic [2:0] {ACC, DRAIN, ACT, CAPT, OUT} state_t;
`endif

    state_t                 state_reg, state_next;
    logic [addrWidth-1:0]   count_reg;
    logic [dataWidth-1:0]   x_reg;
    logic [AW-1:0]          acc_reg;
    logic                   mac_en_reg;
    logic [dataWidth-1:0]   out_data_reg;
    logic                   out_valid_reg;
    logic                   in_ready_c;
    logic                   w_rd_en_c;
    logic                   busy_c;
    logic signed [AW-1:0]   product;

`ifndef NEURON_BIAS_EN
    wire unused_bias = ^bus.bias;
`endif

    // Two's-complement add that clamps to the extreme value on overflow
    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] s;
        s = a + b;
        if ((a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1]))
            s = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return s;
    endfunction

    // ROM data arrives the cycle after the read, so it pairs with the registered sample
    assign product = $signed(x_reg) * $signed(bus.w_data);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ACC;
        else
            state_reg <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state_reg;
        in_ready_c = 1'b0;
        w_rd_en_c  = 1'b0;
        busy_c     = (state_reg != ACC) || (count_reg != '0);
        case (state_reg)
            ACC: begin
                in_ready_c = 1'b1;
                w_rd_en_c  = bus.in_valid;
                if (bus.in_valid && (count_reg == LAST_IDX))
                    state_next = DRAIN;
            end
`ifdef NEURON_BIAS_EN
            DRAIN:   state_next = BIAS;
            BIAS:    state_next = ACT;
`else
            DRAIN:   state_next = ACT;
`endif
            ACT:     state_next = CAPT;
            CAPT:    state_next = OUT;
            OUT:     if (bus.out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Datapath: sample capture, index count, saturating MAC, bias, result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= '0;
            x_reg         <= '0;
            acc_reg       <= '0;
            mac_en_reg    <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            mac_en_reg <= w_rd_en_c;
            if (w_rd_en_c) begin
                x_reg     <= bus.in_data;
                count_reg <= (count_reg == LAST_IDX) ? '0 : count_reg + 1'b1;
            end
            if (mac_en_reg)
                acc_reg <= sat_add(acc_reg, product);
`ifdef NEURON_BIAS_EN
            if (state_reg == BIAS)
                acc_reg <= sat_add(acc_reg, bus.bias);
`endif
            if (state_reg == CAPT) begin
                out_data_reg  <= bus.act_y;
                out_valid_reg <= 1'b1;
            end
            if ((state_reg == OUT) && bus.out_ready) begin
                out_valid_reg <= 1'b0;
                acc_reg       <= '0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.w_rd_en   = w_rd_en_c;
    assign bus.w_addr    = count_reg;
    assign bus.busy      = busy_c;
    assign bus.act_x     = acc_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: directed bench for neuron_seq with numWeight=4, a registered
// weight ROM model and a registered ReLU model on the activation link.
module tb_neuron_seq;
    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int NW  = 4;
    localparam int WIW = 4;
`ifdef NEURON_BIAS_EN
    localparam int          LAT      = 4;
    localparam logic [31:0] BIAS_ACT = 32'h0030_0000;
    localparam logic [15:0] BIAS_OUT = 16'h0300;
`else
    localparam int          LAT      = 3;
    localparam logic [31:0] BIAS_ACT = 32'h0020_0000;
    localparam logic [15:0] BIAS_OUT = 16'h0200;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] rom [NW];

    always #5 clk = ~clk;

    neuron_seq_if #(.dataWidth(DW), .addrWidth(AW)) bus ();

    neuron_seq #(
        .dataWidth(DW), .weightIntWidth(WIW), .numWeight(NW), .addrWidth(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DW-1:0] relu(input logic [2*DW-1:0] x);
        if (x[2*DW-1])
            return '0;
        else if (|x[2*DW-1 -: WIW+1])
            return {1'b0, {(DW-1){1'b1}}};
        else
            return x[2*DW-1-WIW -: DW];
    endfunction

    // Synchronous weight ROM: data one cycle after the read strobe
    always @(posedge clk) if (bus.w_rd_en) bus.w_data <= rom[bus.w_addr[1:0]];

    // External ReLU stage with one registered cycle of latency
    always @(posedge clk) bus.act_y <= relu(bus.act_x);

    task automatic send_frame(input logic [DW-1:0] x, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = x;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 7;
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        if (bus.w_rd_en !== 1'b0)   begin errors++; $display("FAIL reset_w_rd_en got=%b exp=0", bus.w_rd_en); end
        if (bus.w_addr !== '0)      begin errors++; $display("FAIL reset_w_addr got=%h exp=0", bus.w_addr); end
        if (bus.act_x !== '0)       begin errors++; $display("FAIL reset_act_x got=%h exp=0", bus.act_x); end
        if (bus.out_data !== '0)    begin errors++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs at idle values");
    endtask

    task automatic test_positive;
        int lat;
        for (int i = 0; i < NW; i++) rom[i] = 16'h0800;
        for (int i = 0; i < NW; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0100;
            #1;
            checks++;
            if (bus.w_addr !== AW'(i) || bus.w_rd_en !== 1'b1) begin
                errors++;
                $display("FAIL pos_addr got=%0d/%b exp=%0d/1", bus.w_addr, bus.w_rd_en, i);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_out(lat);
        checks += 4;
        if (lat != LAT)                   begin errors++; $display("FAIL pos_latency got=%0d exp=%0d", lat, LAT); end
        if (bus.act_x !== 32'h0020_0000)  begin errors++; $display("FAIL pos_act_x got=%h exp=00200000", bus.act_x); end
        if (bus.out_data !== 16'h0200)    begin errors++; $display("FAIL pos_out_data got=%h exp=0200", bus.out_data); end
        if (bus.busy !== 1'b1)            begin errors++; $display("FAIL pos_busy got=%b exp=1", bus.busy); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks += 3;
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL pos_in_ready_after got=%b exp=1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pos_out_valid_after got=%b exp=0", bus.out_valid); end
        if (bus.act_x !== '0)       begin errors++; $display("FAIL pos_acc_clear got=%h exp=0", bus.act_x); end
        $display("positive: out=%h latency=%0d", bus.out_data, lat);
    endtask

    task automatic test_negative;
        int lat;
        for (int i = 0; i < NW; i++) rom[i] = 16'hF800;
        send_frame(16'h0100, NW);
        wait_out(lat);
        checks += 2;
        if (bus.act_x !== 32'hFFE0_0000) begin errors++; $display("FAIL neg_act_x got=%h exp=ffe00000", bus.act_x); end
        if (bus.out_data !== 16'h0000)   begin errors++; $display("FAIL neg_out_data got=%h exp=0000", bus.out_data); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("negative: out=%h", bus.out_data);
    endtask

    task automatic test_saturate;
        int lat;
        for (int i = 0; i < NW; i++) rom[i] = 16'h7FFF;
        for (int i = 0; i < NW; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h7FFF;
            @(negedge clk);
            if (i == 2) begin
                checks++;
                if (bus.act_x !== 32'h7FFE_0002) begin errors++; $display("FAIL sat_two_adds got=%h exp=7ffe0002", bus.act_x); end
            end
            if (i == 3) begin
                checks++;
                if (bus.act_x !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_clamp got=%h exp=7fffffff", bus.act_x); end
            end
        end
        bus.in_valid = 1'b0;
        wait_out(lat);
        checks += 2;
        if (bus.act_x !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_final got=%h exp=7fffffff", bus.act_x); end
        if (bus.out_data !== 16'h7FFF)   begin errors++; $display("FAIL sat_out_data got=%h exp=7fff", bus.out_data); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("saturate: out=%h", bus.out_data);
    endtask

    task automatic test_bias;
        int lat;
        for (int i = 0; i < NW; i++) rom[i] = 16'h0800;
        bus.bias = 32'h0010_0000;
        send_frame(16'h0100, NW);
        wait_out(lat);
        checks += 3;
        if (lat != LAT)                 begin errors++; $display("FAIL bias_latency got=%0d exp=%0d", lat, LAT); end
        if (bus.act_x !== BIAS_ACT)     begin errors++; $display("FAIL bias_act_x got=%h exp=%h", bus.act_x, BIAS_ACT); end
        if (bus.out_data !== BIAS_OUT)  begin errors++; $display("FAIL bias_out_data got=%h exp=%h", bus.out_data, BIAS_OUT); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.bias = '0;
        $display("bias: out=%h latency=%0d", bus.out_data, lat);
    endtask

    task automatic test_backpressure;
        int lat;
        for (int i = 0; i < NW; i++) rom[i] = 16'h0800;
        send_frame(16'h0100, NW);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1234;
            #1;
            checks += 2;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
            if (bus.w_rd_en !== 1'b0)  begin errors++; $display("FAIL bp_w_rd_en got=%b exp=0", bus.w_rd_en); end
            @(negedge clk);
            checks += 2;
            if (bus.out_valid !== 1'b1)    begin errors++; $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); end
            if (bus.out_data !== 16'h0200) begin errors++; $display("FAIL bp_out_data got=%h exp=0200", bus.out_data); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
        if (bus.busy !== 1'b0)     begin errors++; $display("FAIL bp_busy got=%b exp=0", bus.busy); end
        $display("backpressure: held out=%h for 5 cycles", bus.out_data);
    endtask

    task automatic test_back_to_back;
        int lat;
        for (int i = 0; i < NW; i++) rom[i] = 16'h0800;
        bus.out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            send_frame(16'h0100, NW);
            wait_out(lat);
            checks += 2;
            if (bus.out_data !== 16'h0200) begin errors++; $display("FAIL b2b_out_data got=%h exp=0200", bus.out_data); end
            if (lat != LAT)                begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
            $display("back_to_back: frame %0d out=%h", f, bus.out_data);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midframe;
        int lat;
        for (int i = 0; i < NW; i++) rom[i] = 16'h0800;
        send_frame(16'h0100, 2);
        rst = 1'b1;
        #1;
        checks += 5;
        if (bus.w_addr !== '0)      begin errors++; $display("FAIL mid_w_addr got=%h exp=0", bus.w_addr); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        if (bus.act_x !== '0)       begin errors++; $display("FAIL mid_act_x got=%h exp=0", bus.act_x); end
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(16'h0100, NW);
        wait_out(lat);
        checks += 2;
        if (bus.act_x !== 32'h0020_0000) begin errors++; $display("FAIL mid_frame_act_x got=%h exp=00200000", bus.act_x); end
        if (bus.out_data !== 16'h0200)   begin errors++; $display("FAIL mid_frame_out got=%h exp=0200", bus.out_data); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("reset_midframe: recovered out=%h", bus.out_data);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.bias      = '0;
        for (int i = 0; i < NW; i++) rom[i] = '0;
        test_reset();
        test_positive();
        test_negative();
        test_saturate();
        test_bias();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
